// File: rtl/cpu_pkg.sv
// Shared CPU encodings: ALU op select and the divider sequencer state.
package cpu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_MUL = 2'b01,
        ALU_DIV = 2'b10,
        ALU_MOD = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_t;

    function automatic logic is_divmod(input logic [1:0] op);
        return (op == ALU_DIV) || (op == ALU_MOD);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, conditionally subtract.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        // Remainder stays below divisor, so WIDTH bits always hold it.
        if (shifted >= {1'b0, divisor}) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_mod_sequencer.sv
// Multi-cycle unsigned DIV/MOD unit: stalls the pipeline for WIDTH steps and
// pulses Done with the quotient or remainder.
module div_mod_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Flush,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             DivZero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state, state_nx;
    alu_op_t          op;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, divisor;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic             accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        Stall    = 1'b0;
        Done     = 1'b0;
        case (state)
            IDLE: begin
                // Flush wins over Start so a squashed instruction never stalls.
                if (reset && Start && is_divmod(ALUControl) && !Flush) begin
                    accept   = 1'b1;
                    Stall    = 1'b1;
                    state_nx = (SrcB == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                Stall = 1'b1;
                if (Flush)          state_nx = IDLE;
                else if (cnt == '0) state_nx = DONE;
            end
            DONE: begin
                Done     = !Flush;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op      <= ALU_DIV;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            Result  <= '0;
            DivZero <= 1'b0;
        end else if (accept) begin
            op      <= alu_op_t'(ALUControl);
            cnt     <= CW'(WIDTH - 1);
            rem     <= '0;
            quo     <= SrcA;
            divisor <= SrcB;
            // Divide by zero goes straight to DONE with the architectural result.
            if (SrcB == '0) begin
                Result  <= (ALUControl == ALU_MOD) ? SrcA : '1;
                DivZero <= 1'b1;
            end
        end else if (state == RUN && !Flush) begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
                Result  <= (op == ALU_MOD) ? rem_nx : quo_nx;
                DivZero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_mod_sequencer.sv
// Directed bench for div_mod_sequencer: latency, results, divide-by-zero, flush, reset.
module tb_div_mod_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [1:0]  ALUControl;
    logic [31:0] SrcA, SrcB;
    logic        Flush;
    logic        Stall, Done, DivZero;
    logic [31:0] Result;

    int n_cmp = 0;
    int n_err = 0;

    div_mod_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .Start      (Start),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .Flush      (Flush),
        .Stall      (Stall),
        .Done       (Done),
        .Result     (Result),
        .DivZero    (DivZero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Accept in cycle 0, scribble on inputs during RUN and DONE, expect Done in cycle lat.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] exp_res,
                          input logic exp_dz);
        @(negedge clk);
        Start = 1'b1; ALUControl = op; SrcA = a; SrcB = b; Flush = 1'b0;
        #1 chk({tag, " stall_accept"}, 32'(Stall), 32'd1);
        chk({tag, " done_accept"}, 32'(Done), 32'd0);
        for (int c = 1; c < lat; c++) begin
            @(negedge clk);
            Start = 1'b1; ALUControl = 2'($urandom); SrcA = $urandom; SrcB = $urandom;
            #1 chk({tag, " stall_run"}, 32'(Stall), 32'd1);
            chk({tag, " done_run"}, 32'(Done), 32'd0);
        end
        @(negedge clk);
        Start = 1'b1; ALUControl = ALU_DIV; SrcA = 32'd50; SrcB = 32'd0;
        #1 chk({tag, " done_pulse"}, 32'(Done), 32'd1);
        chk({tag, " stall_done"}, 32'(Stall), 32'd0);
        chk({tag, " result"}, Result, exp_res);
        chk({tag, " divzero"}, 32'(DivZero), 32'(exp_dz));
        @(negedge clk);
        Start = 1'b0;
        #1 chk({tag, " done_after"}, 32'(Done), 32'd0);
        chk({tag, " stall_after"}, 32'(Stall), 32'd0);
        chk({tag, " result_hold"}, Result, exp_res);
    endtask

    initial begin
        reset = 1'b0; Start = 1'b0; ALUControl = 2'b00; SrcA = '0; SrcB = '0; Flush = 1'b0;
        @(negedge clk);
        #1 chk("rst stall", 32'(Stall), 32'd0);
        chk("rst done", 32'(Done), 32'd0);
        chk("rst result", Result, 32'd0);
        chk("rst divzero", 32'(DivZero), 32'd0);
        reset = 1'b1;

        run_op("div100_7", ALU_DIV, 32'd100, 32'd7, 33, 32'd14, 1'b0);
        run_op("mod100_7", ALU_MOD, 32'd100, 32'd7, 33, 32'd2, 1'b0);
        run_op("div_max_1", ALU_DIV, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 1'b0);

        // ADD and MUL requests must not be taken.
        @(negedge clk);
        Start = 1'b1; ALUControl = ALU_ADD; SrcA = 32'd9; SrcB = 32'd0;
        #1 chk("add stall", 32'(Stall), 32'd0);
        @(negedge clk);
        ALUControl = ALU_MUL;
        #1 chk("mul stall", 32'(Stall), 32'd0);
        chk("add done", 32'(Done), 32'd0);
        @(negedge clk);
        Start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1 chk("add idle_done", 32'(Done), 32'd0);
            chk("add idle_stall", 32'(Stall), 32'd0);
        end
        chk("add result_kept", Result, 32'hFFFF_FFFF);

        run_op("div5_0", ALU_DIV, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 1'b1);
        run_op("mod5_0", ALU_MOD, 32'd5, 32'd0, 1, 32'd5, 1'b1);

        // Flush alongside Start in IDLE: not accepted.
        @(negedge clk);
        Start = 1'b1; ALUControl = ALU_DIV; SrcA = 32'd7; SrcB = 32'd0; Flush = 1'b1;
        #1 chk("flush_idle stall", 32'(Stall), 32'd0);
        @(negedge clk);
        Start = 1'b0; Flush = 1'b0;
        #1 chk("flush_idle done", 32'(Done), 32'd0);
        chk("flush_idle stall_next", 32'(Stall), 32'd0);

        // Flush in cycle 10 of DIV 100/7.
        @(negedge clk);
        Start = 1'b1; ALUControl = ALU_DIV; SrcA = 32'd100; SrcB = 32'd7;
        #1 chk("flush_run stall_accept", 32'(Stall), 32'd1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            Start = 1'b0;
            Flush = (c == 10);
            #1 chk("flush_run stall_run", 32'(Stall), 32'd1);
        end
        for (int c = 11; c < 45; c++) begin
            @(negedge clk);
            Flush = 1'b0;
            #1 chk("flush_run stall_idle", 32'(Stall), 32'd0);
            chk("flush_run no_done", 32'(Done), 32'd0);
        end
        chk("flush_run result_kept", Result, 32'd5);
        chk("flush_run divzero_kept", 32'(DivZero), 32'd1);

        // Reset low in cycle 15 of RUN, away from any clock edge.
        @(negedge clk);
        Start = 1'b1; ALUControl = ALU_DIV; SrcA = 32'd100; SrcB = 32'd7;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            Start = 1'b0;
            #1 chk("rst_run stall_run", 32'(Stall), 32'd1);
        end
        #1 reset = 1'b0;
        #1 chk("rst_run stall", 32'(Stall), 32'd0);
        chk("rst_run done", 32'(Done), 32'd0);
        chk("rst_run result", Result, 32'd0);
        chk("rst_run divzero", 32'(DivZero), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("div9_3", ALU_DIV, 32'd9, 32'd3, 33, 32'd3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
